// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch path between cpu_top and the
// instruction memory responder.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    // Fetch interface widths
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = INSTR_W;

    // Latency counter width; bounds the legal LATENCY range to 1..15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_t;

    // Instruction fetches and preloads are whole-word only
    function automatic logic word_aligned(input logic [1:0] byte_off);
        return byte_off == 2'b00;
    endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Word RAM behind the responder: synchronous write, registered read.
// A read and a write to the same word on one edge return the old word.
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    // Storage is deliberately not reset so preloaded program survives reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data only moves on a new read, so it holds across later writes
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: memory end of the fetch request/response
// interface, with fixed latency, flush cancel and a preload port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a fetch; a handshake captures word + error flag
// WAIT    | counting down the remaining latency
// RESP    | response presented and held until resp_ready (or flush)
module imem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2    // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [INSTR_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [INSTR_W-1:0] ld_data
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   ld_idx;
    logic               req_bad;
    logic               ld_ok;
    logic               accept;
    logic [INSTR_W-1:0] rd_data;

    assign req_idx = req_addr[ADDR_W-1:2];
    assign ld_idx  = ld_addr[ADDR_W-1:2];

    // Misaligned or out-of-range fetches answer with an error, loads are dropped
    assign req_bad = !word_aligned(req_addr[1:0]) || (req_idx >= DEPTH_IDX);
    assign ld_ok   = ld_en && word_aligned(ld_addr[1:0]) && (ld_idx < DEPTH_IDX);

    // A flush in IDLE blocks acceptance even though req_ready stays high
    assign accept  = (state_q == ST_IDLE) && req_valid && !flush;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (INSTR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (ld_ok),
        .wr_addr (ld_idx[AW-1:0]),
        .wr_data (ld_data),
        .rd_en   (accept && !req_bad),
        .rd_addr (req_idx[AW-1:0]),
        .rd_data (rd_data)
    );

    // State register with counter and captured error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: the counter holds cycles still to wait, so WAIT leaves when
    // it would decrement to zero, giving resp_valid LATENCY cycles after accept
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d   = req_bad;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from state; error responses carry zero data
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_err   = (state_q == ST_RESP) && err_q;
        resp_data  = '0;
        if ((state_q == ST_RESP) && !err_q) begin
            resp_data = rd_data;
        end
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder serving the fetch stage of cpu_top: the memory end of the fetch request/response interface.
- Accepts one word-aligned fetch request at a time.
- Returns the 32-bit instruction after a fixed, parameterised latency; holds it under backpressure.
- Supports flush-cancel of an in-flight fetch (branch redirect).
- Provides a load port for boot/bench preload of program contents.

Parameters:
ADDR_W, 32, byte-address width of fetch and load addresses
DEPTH, 256, number of 32-bit instruction words stored
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  fetch request valid
req_ready  output  1  responder can accept a request
req_addr  input  ADDR_W  byte address of instruction (PC)
resp_valid  output  1  response valid
resp_ready  input  1  fetch stage accepts response
resp_data  output  32  instruction word
resp_err  output  1  misaligned or out-of-range request
flush  input  1  cancel in-flight fetch
ld_en  input  1  preload write enable
ld_addr  input  ADDR_W  preload byte address, word-aligned
ld_data  input  32  preload word

Behaviour:
- Reset (synchronous, active-high) forces: state IDLE, req_ready=1 on the following cycle, resp_valid=0, resp_data=0, resp_err=0, latency counter=0. Memory array is not cleared. Reset mid-operation drops any in-flight request with no response.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A handshake (req_valid && req_ready) at edge T captures the word and error status, loads the counter with LATENCY-1, and moves to WAIT; if LATENCY==1, it moves directly to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; on 0, move to RESP.
  - RESP: resp_valid=1, req_ready=0. resp_data and resp_err stay stable until resp_valid && resp_ready, then return to IDLE.
- Latency: resp_valid first high exactly LATENCY cycles after the accepting edge.
- Throughput: one request per LATENCY+1 cycles minimum. The next accept happens no earlier than the cycle after the response handshake.
- Data capture: the word is read at the accepting edge. A later ld_en write to the same word does not alter the pending response.
- Errors:
  - req_addr[1:0]!=0: resp_err=1, resp_data=0.
  - Word index req_addr[ADDR_W-1:2] >= DEPTH: resp_err=1, resp_data=0.
  - Error responses use the normal latency and handshake.
- Flush:
  - In WAIT or RESP: return to IDLE next cycle, resp_valid=0, response discarded.
  - In IDLE: a coincident req_valid is not accepted that cycle.
  - Flush with resp_ready in RESP: flush wins; the response is not counted as delivered.
- Load port:
  - ld_en writes ld_data to word ld_addr[ADDR_W-1:2] at the edge, in any state.
  - Misaligned or out-of-range loads are ignored.
  - Simultaneous load and accept at the same address: the request returns the old word (read-before-write).
- Width rules: the index is a truncation of ADDR_W-2 bits compared against DEPTH. The counter is 4 bits.

Decomposition:
- Shared package cpu_pkg: INSTR_W=32, NOP encoding constant, FSM state encodings, fetch interface width constants.
- One sub-module, imem_array: synchronous-write, registered-read word RAM (DEPTH x 32) with read-before-write semantics. The FSM, counter and error checks stay in imem_responder.

Test Plan:
- Preload words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00308193. Request addr 0x4 with resp_ready=1 and LATENCY=2 -> resp_valid exactly 2 cycles after accept, resp_data=0x00100093, resp_err=0, req_ready=0 until the handshake.
- Request 0x8, hold resp_ready=0 for 5 cycles -> resp_valid and resp_data=0x00200113 stable throughout; accept on the cycle resp_ready rises; IDLE next cycle.
- Request 0x6 -> resp_err=1, resp_data=0. Request 0x400 with DEPTH=256 -> resp_err=1, resp_data=0.
- Accept 0xC, assert flush one cycle later -> no resp_valid ever; req_ready=1 the cycle after flush; new request 0x0 returns 0x00000013.
- Accept 0x0 while ld_en writes 0xDEADBEEF to 0x0 on the same edge -> response 0x00000013; a second fetch of 0x0 returns 0xDEADBEEF.
- Assert reset during WAIT -> resp_valid stays 0, req_ready=1 the cycle after reset deasserts, preloaded memory contents intact.
